// File: rtl/bch_correct_buffer.sv
// Holds the data part of a received BCH codeword and XORs the Chien error stream into it.
// Latency: corrected word valid one cycle after the last error beat is accepted.
// Backpressure: the held word waits indefinitely on out_ready_o; no new load starts until it drains.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   in_ready_o/in_start_i/in_valid_i   data-beat intake (in_data_i, first-transmitted bits first)
//   err_first_i/err_valid_i/err_i      Chien error-mask beats, same ordering as the data beats
//   data_out_o/corr_count_o            corrected word (first beat in the MSBs) and flipped-bit count
//   out_valid_o/out_ready_i            output handshake
//   proto_err_o                        one-cycle pulse for an error beat arriving in the wrong state
module bch_correct_buffer #(
    parameter int DATA_BITS = 5,
    parameter int BITS      = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    output logic                               in_ready_o,
    input  logic                               in_start_i,
    input  logic                               in_valid_i,
    input  logic [BITS-1:0]                    in_data_i,
    input  logic                               err_first_i,
    input  logic                               err_valid_i,
    input  logic [BITS-1:0]                    err_i,
    output logic [DATA_BITS-1:0]               data_out_o,
    output logic [$clog2(DATA_BITS+1)-1:0]     corr_count_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic                               proto_err_o
);

    localparam int BEATS = DATA_BITS / BITS;
    localparam int CW    = $clog2(BEATS + 1);
    localparam int CCW   = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_ERR, CORRECT, HOLD} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [DATA_BITS-1:0]   data_q;
    logic [CCW-1:0]         corr_q;
    logic                   out_valid_q;
    logic                   in_ready_q;
    logic                   proto_err_q;

    logic [DATA_BITS-1:0]   shift_d;
    logic [DATA_BITS-1:0]   rot_d;
    logic [CCW-1:0]         pop_d;
    logic [CCW:0]           corr_sum_d;
    logic [CCW-1:0]         corr_sat_d;
    logic [CW-1:0]          cnt_inc_d;
    logic                   last_d;
    logic                   proto_d;

    always_comb begin
        // Load shifts new beats in at the bottom, so the first beat ends up in the MSBs.
        shift_d = (data_q << BITS) | DATA_BITS'(in_data_i);
        // Correction rotates the oldest beat out of the top, XORs its mask and re-inserts it at
        // the bottom; after BEATS rotations the word is back in its original order.
        rot_d   = (data_q << BITS) | DATA_BITS'(data_q[DATA_BITS-1 -: BITS] ^ err_i);

        pop_d = '0;
        for (int i = 0; i < BITS; i++) begin
            pop_d = pop_d + CCW'(err_i[i]);
        end
        corr_sum_d = {1'b0, corr_q} + {1'b0, pop_d};
        corr_sat_d = (corr_sum_d > (CCW+1)'(DATA_BITS)) ? CCW'(DATA_BITS) : corr_sum_d[CCW-1:0];

        cnt_inc_d = cnt_q + CW'(1);
        last_d    = (cnt_inc_d == CW'(BEATS));

        // err_first is legal only in WAIT_ERR; err_valid is legal in WAIT_ERR (ignored) and CORRECT.
        proto_d = (err_first_i && (state_q != WAIT_ERR)) ||
                  (err_valid_i && ((state_q == IDLE) || (state_q == LOAD) || (state_q == HOLD)));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            corr_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_d;
            case (state_q)
                IDLE: begin
                    if (in_ready_q && in_start_i && in_valid_i) begin
                        data_q     <= shift_d;
                        cnt_q      <= CW'(1);
                        in_ready_q <= 1'b0;
                        state_q    <= (BEATS == 1) ? WAIT_ERR : LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid_i) begin
                        data_q <= shift_d;
                        cnt_q  <= cnt_inc_d;
                        if (last_d) begin
                            state_q <= WAIT_ERR;
                        end
                    end
                end
                WAIT_ERR: begin
                    if (err_first_i) begin
                        data_q <= rot_d;
                        corr_q <= pop_d;
                        cnt_q  <= CW'(1);
                        if (BEATS == 1) begin
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= CORRECT;
                        end
                    end
                end
                CORRECT: begin
                    if (err_valid_i) begin
                        data_q <= rot_d;
                        corr_q <= corr_sat_d;
                        cnt_q  <= cnt_inc_d;
                        if (last_d) begin
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o   = in_ready_q;
    assign data_out_o   = data_q;
    assign corr_count_o = corr_q;
    assign out_valid_o  = out_valid_q;
    assign proto_err_o  = proto_err_q;

endmodule
